// File: rtl/j2c_pkg.sv
// Shared definitions for the J2C transmit arbiter: FSM states, idle line
// levels and frame geometry helpers.
package j2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_BIT_LO = 3'd2,
        ST_BIT_HI = 3'd3,
        ST_STOP0  = 3'd4,
        ST_STOP1  = 3'd5,
        ST_STOP2  = 3'd6
    } j2c_state_e;

    localparam logic SDA_IDLE = 1'b1;
    localparam logic SCL_IDLE = 1'b1;

    // Width of the requester ID field carried at the head of every frame.
    function automatic int id_width(input int nreq);
        if (nreq > 2) begin
            return $clog2(nreq);
        end else begin
            return 1;
        end
    endfunction

    // Frame length in cycles, START through STOP2 inclusive.
    function automatic int frame_len(input int nbits, input int nreq);
        return 2 * (id_width(nreq) + nbits) + 4;
    endfunction

endpackage

// File: rtl/j2c_rr_arbiter.sv
// Combinational round-robin picker. The search starts at 'pointer' and wraps;
// the pointer register itself lives in the caller so it advances only on an
// accepted handshake.
module j2c_rr_arbiter
    import j2c_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  pointer,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

    logic [NREQ-1:0] hi_mask_s;
    logic [NREQ-1:0] hi_req_s;
    logic [NREQ-1:0] sel_s;
    logic            found_s;

    // Prefer valid requesters at or above the pointer; otherwise wrap to the
    // lowest valid one. The first set bit of the chosen set wins.
    always_comb begin
        hi_mask_s = '0;
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            hi_mask_s[j] = (j >= int'(pointer));
        end
        hi_req_s  = req_valid & hi_mask_s;
        sel_s     = (|hi_req_s) ? hi_req_s : req_valid;
        any_valid = |req_valid;
        for (int j = 0; j < NREQ; j++) begin
            if (sel_s[j] && !found_s) begin
                found_s   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end else begin
                found_s   = found_s;
            end
        end
    end

endmodule

// File: rtl/j2c_tx_arbiter.sv
// Shares one J2C serial output between NREQ producers. A round-robin winner's
// word is accepted in IDLE, prefixed with its ID and shifted out MSB-first
// framed by START and STOP conditions.
module j2c_tx_arbiter
    import j2c_pkg::*;
#(
    parameter  int NBITS = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*NBITS-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  sda,
    output logic                  scl,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  frame_done
);

    localparam int             FW       = IDW + NBITS;
    localparam int             CW       = $clog2(FW) + 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(FW);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [IDW-1:0] PTR_LAST = IDW'(NREQ - 1);

    j2c_state_e     state_r, state_nxt_s;
    logic [IDW-1:0] ptr_r, ptr_nxt_s;
    logic [FW-1:0]  sh_r, sh_nxt_s;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    logic [IDW-1:0] grant_id_r, grant_id_nxt_s;
    logic           sda_r, sda_nxt_s;
    logic           scl_r, scl_nxt_s;
    logic           busy_r, busy_nxt_s;
    logic           done_r, done_nxt_s;

    logic [NREQ-1:0]  win_oh_s;
    logic [IDW-1:0]   win_idx_s;
    logic             any_valid_s;
    logic [NBITS-1:0] win_data_s;

    j2c_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_valid (req_valid),
        .pointer   (ptr_r),
        .grant     (win_oh_s),
        .grant_idx (win_idx_s),
        .any_valid (any_valid_s)
    );

    // Offer the winner only while idle and out of reset; a word can never be
    // accepted while a frame is in flight.
    assign req_ready = (state_r == ST_IDLE && rstn) ? win_oh_s : '0;

    // One-hot AND-OR mux selecting the winner's data word.
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_data_s = win_data_s | ({NBITS{win_oh_s[i]}} & req_data[i*NBITS +: NBITS]);
        end
    end

    // Next-state logic, then line levels derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        sh_nxt_s       = sh_r;
        cnt_nxt_s      = cnt_r;
        grant_id_nxt_s = grant_id_r;
        sda_nxt_s      = SDA_IDLE;
        scl_nxt_s      = SCL_IDLE;

        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s    = ST_START;
                    sh_nxt_s       = {win_idx_s, win_data_s};
                    cnt_nxt_s      = CNT_LOAD;
                    grant_id_nxt_s = win_idx_s;
                    ptr_nxt_s      = (win_idx_s == PTR_LAST) ? '0 : win_idx_s + IDW'(1);
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_START:  state_nxt_s = ST_BIT_LO;
            ST_BIT_LO: state_nxt_s = ST_BIT_HI;
            ST_BIT_HI: begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_STOP0;
                end else begin
                    state_nxt_s = ST_BIT_LO;
                    sh_nxt_s    = {sh_r[FW-2:0], 1'b0};
                end
            end
            ST_STOP0:  state_nxt_s = ST_STOP1;
            ST_STOP1:  state_nxt_s = ST_STOP2;
            ST_STOP2:  state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase

        case (state_nxt_s)
            ST_IDLE:   begin sda_nxt_s = SDA_IDLE;       scl_nxt_s = SCL_IDLE; end
            ST_START:  begin sda_nxt_s = 1'b0;           scl_nxt_s = 1'b1;     end
            ST_BIT_LO: begin sda_nxt_s = sh_nxt_s[FW-1]; scl_nxt_s = 1'b0;     end
            ST_BIT_HI: begin sda_nxt_s = sh_nxt_s[FW-1]; scl_nxt_s = 1'b1;     end
            ST_STOP0:  begin sda_nxt_s = 1'b0;           scl_nxt_s = 1'b0;     end
            ST_STOP1:  begin sda_nxt_s = 1'b0;           scl_nxt_s = 1'b1;     end
            ST_STOP2:  begin sda_nxt_s = 1'b1;           scl_nxt_s = 1'b1;     end
            default:   begin sda_nxt_s = SDA_IDLE;       scl_nxt_s = SCL_IDLE; end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_STOP2);
    end

    // State, datapath and glitch-free registered line outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            sh_r       <= '0;
            cnt_r      <= '0;
            grant_id_r <= '0;
            sda_r      <= SDA_IDLE;
            scl_r      <= SCL_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            sh_r       <= sh_nxt_s;
            cnt_r      <= cnt_nxt_s;
            grant_id_r <= grant_id_nxt_s;
            sda_r      <= sda_nxt_s;
            scl_r      <= scl_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign sda        = sda_r;
    assign scl        = scl_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;
    assign frame_done = done_r;

endmodule

// File: doc/j2c_tx_arbiter.md
Name: j2c_tx_arbiter

Overview:
Round-robin scheduler and frame sequencer that shares one J2C serial output (sda/scl) between NREQ requesters. It accepts one word per frame through a valid/ready handshake, prefixes the word with the winner's ID field, and serialises the frame MSB-first. It sits between the on-chip producers and the J2C pins, replacing direct per-producer master instances.

Parameters:
NBITS, 8, data word width per frame
NREQ, 4, number of requesters (2..16)
IDW, max(1,$clog2(NREQ)), width of the ID field (derived, not overridable)

Ports:
clk  input  1  system clock; all logic on posedge
rstn  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester word valid
req_data  input  NREQ*NBITS  flattened words; requester i occupies bits [i*NBITS +: NBITS]
req_ready  output  NREQ  one-hot accept strobe
sda  output  1  serial data line
scl  output  1  serial clock line
busy  output  1  high from the START cycle through the STOP2 cycle
grant_id  output  IDW  ID of the current or last granted requester
frame_done  output  1  one-cycle pulse during the STOP2 cycle

Behaviour:
- Reset (rstn=0, async): sda=1, scl=1, busy=0, frame_done=0, grant_id=0, req_ready=0, state=IDLE, priority pointer=0, shift register cleared.
- States: IDLE, START, BIT_LO, BIT_HI, STOP0, STOP1, STOP2.
- IDLE: sda=1, scl=1. Search req_valid round-robin starting at the pointer. req_ready = one-hot of the winner; this is combinational from req_valid and is asserted only in IDLE. If no requester is valid, req_ready=0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. On that edge:
  - latch {i[IDW-1:0], req_data[i]} into the (IDW+NBITS)-bit shift register
  - grant_id <= i
  - pointer <= (i+1) mod NREQ
  - state <= START
- Requesters must hold valid and data stable until accepted. Data is not sampled after the handshake.
- START (1 cycle): sda=0, scl=1, busy=1.
- Per bit, MSB first, ID field before data, IDW+NBITS bits in total:
  - BIT_LO (1 cycle): scl=0, sda=bit.
  - BIT_HI (1 cycle): scl=1, sda=bit unchanged.
  - Receivers sample sda on the scl rising edge.
  - A bit counter of width $clog2(IDW+NBITS)+1 counts down. After the last BIT_HI, go to STOP0.
- STOP0: scl=0, sda=0. STOP1: scl=1, sda=0. STOP2: scl=1, sda=1, frame_done=1. Then IDLE.
- Frame length from START to STOP2 inclusive: 2*(IDW+NBITS)+4 cycles (24 for the defaults).
- Minimum spacing between frames: exactly 1 IDLE cycle (the handshake cycle).
- sda, scl, busy and frame_done are registered: they reflect state on the cycle after the transition edge. They never glitch.
- sda changes only while scl=0, except at START and STOP2 (the intended conditions).
- Reset mid-frame: outputs return immediately to idle levels and no STOP is generated. The pointer returns to 0. A word accepted before the reset is lost; its requester re-presents it.
- Valid asserted while busy: no effect until IDLE, and req_ready stays 0.
- NREQ not a power of two: IDs NREQ..2^IDW-1 are never emitted.

Decomposition:
- Package j2c_pkg:
  - state enum
  - idle levels SDA_IDLE=1, SCL_IDLE=1
  - function id_width(nreq)
  - frame_len(nbits, nreq) constant for benches
- Sub-module j2c_rr_arbiter (NREQ): inputs req_valid, pointer; outputs one-hot grant, grant index, any_valid. It is purely combinational. The pointer register stays in the top level so the FSM controls when it advances.

Test Plan:
- Reset with rstn=0 -> sda=1, scl=1, busy=0, req_ready=0000. After release with no valid, the outputs stay idle for 50 cycles.
- NREQ=4, NBITS=8, only req 2 valid, data 0xA5 -> req_ready=0100 for 1 cycle. The 24-cycle frame is START, ID bits 1,0, data 1,0,1,0,0,1,0,1, STOP. grant_id=2 and frame_done pulses once.
- All four valid continuously -> grants in order 0,1,2,3,0. Consecutive STOP2 and START are separated by exactly 1 cycle. The four frames decode to the four words.
- After a grant to 1, with req 0 and 3 valid -> 3 is served before 0.
- rstn pulsed low at cycle 10 of a frame -> sda=scl=1 and busy=0 in the same cycle, with no frame_done. After release, pending req 1 is re-sent in full with pointer 0 priority.
- Granted requester changes req_data after the handshake, and an ungranted requester toggles its data during the frame -> the serialised word equals the value latched at the handshake. No spurious req_ready appears while busy.
